// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the MIPS core: register-specifier width, the $0
// constant and the hazard scoreboard entry.
package mips_pipe_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request / forwarding-control bundle between the decode stage and
// fwd_hazard_ctrl.
interface fwd_hazard_ctrl_if;
    import mips_pipe_pkg::*;

    // Handshake: there is no valid/ready pair. id_valid qualifies the ID fields
    // for the current cycle; stall is the back-pressure answer in that same
    // cycle (ID must be presented again), bubble says ID/EX loads a NOP.
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;

    logic             stall;
    logic             bubble;
    logic             fwd_a_mem;
    logic             fwd_a_wb;
    logic             fwd_b_mem;
    logic             fwd_b_wb;

    // Observation of the scoreboard and of the raw load hits {a_ex, b_ex, a_mem, b_mem}.
    sb_entry_t        dbg_ex;
    sb_entry_t        dbg_mem;
    sb_entry_t        dbg_wb;
    logic [3:0]       dbg_load_hits;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_regwrite, id_memread, flush,
        input  stall, bubble, fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb,
               dbg_ex, dbg_mem, dbg_wb, dbg_load_hits
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_regwrite, id_memread, flush,
        output stall, bubble, fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb,
               dbg_ex, dbg_mem, dbg_wb, dbg_load_hits
    );

endinterface

// File: rtl/fwd_src_match.sv
// Compares one source specifier against one scoreboard entry: does the entry
// produce that register, and is it a load producing it.
module fwd_src_match
    import mips_pipe_pkg::*;
(
    input  logic             uses,
    input  logic [REG_W-1:0] src,
    input  sb_entry_t        entry,
    output logic             produces,
    output logic             load_hit
);

    // $0 is hard-wired, so it never matches regardless of the entry.
    assign produces = uses && entry.valid && entry.regwrite &&
                      (entry.rd == src) && (src != REG_ZERO);
    assign load_hit = produces && entry.memread;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall/bubble generation for the 5-stage MIPS
// pipeline. Optional stall counter when FWD_HAZ_STALL_CNT_EN is defined.
module fwd_hazard_ctrl
    import mips_pipe_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    fwd_hazard_ctrl_if.slave bus
`ifdef FWD_HAZ_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    sb_entry_t sb_ex, sb_mem, sb_wb;
    sb_entry_t id_entry;

    logic a_ex_prod, a_ex_load, a_mem_prod, a_mem_load;
    logic b_ex_prod, b_ex_load, b_mem_prod, b_mem_load;
    logic stall_raw, bubble_int;
    logic fwd_a_mem_q, fwd_a_wb_q, fwd_b_mem_q, fwd_b_wb_q;

    fwd_src_match u_a_ex (
        .uses(bus.id_uses_rs), .src(bus.id_rs), .entry(sb_ex),
        .produces(a_ex_prod), .load_hit(a_ex_load)
    );
    fwd_src_match u_a_mem (
        .uses(bus.id_uses_rs), .src(bus.id_rs), .entry(sb_mem),
        .produces(a_mem_prod), .load_hit(a_mem_load)
    );
    fwd_src_match u_b_ex (
        .uses(bus.id_uses_rt), .src(bus.id_rt), .entry(sb_ex),
        .produces(b_ex_prod), .load_hit(b_ex_load)
    );
    fwd_src_match u_b_mem (
        .uses(bus.id_uses_rt), .src(bus.id_rt), .entry(sb_mem),
        .produces(b_mem_prod), .load_hit(b_mem_load)
    );

    assign id_entry = '{valid: 1'b1, rd: bus.id_rd,
                        regwrite: bus.id_regwrite, memread: bus.id_memread};

    // A flush kills the consumer, so it overrides any load-use stall.
    assign stall_raw  = bus.id_valid && !bus.flush && (a_ex_load || b_ex_load);
    assign bubble_int = stall_raw || bus.flush || !bus.id_valid;

    assign bus.stall  = !Rst && stall_raw;
    assign bus.bubble = !Rst && bubble_int;

    // The younger producer (EX now, MEM next cycle) takes priority over the older one.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sb_ex       <= SB_EMPTY;
            sb_mem      <= SB_EMPTY;
            sb_wb       <= SB_EMPTY;
            fwd_a_mem_q <= 1'b0;
            fwd_a_wb_q  <= 1'b0;
            fwd_b_mem_q <= 1'b0;
            fwd_b_wb_q  <= 1'b0;
        end else begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            if (bubble_int) begin
                sb_ex       <= SB_EMPTY;
                fwd_a_mem_q <= 1'b0;
                fwd_a_wb_q  <= 1'b0;
                fwd_b_mem_q <= 1'b0;
                fwd_b_wb_q  <= 1'b0;
            end else begin
                sb_ex       <= id_entry;
                fwd_a_mem_q <= a_ex_prod;
                fwd_a_wb_q  <= a_mem_prod && !a_ex_prod;
                fwd_b_mem_q <= b_ex_prod;
                fwd_b_wb_q  <= b_mem_prod && !b_ex_prod;
            end
        end
    end

    assign bus.fwd_a_mem     = fwd_a_mem_q;
    assign bus.fwd_a_wb      = fwd_a_wb_q;
    assign bus.fwd_b_mem     = fwd_b_mem_q;
    assign bus.fwd_b_wb      = fwd_b_wb_q;
    assign bus.dbg_ex        = sb_ex;
    assign bus.dbg_mem       = sb_mem;
    assign bus.dbg_wb        = sb_wb;
    assign bus.dbg_load_hits = {a_ex_load, b_ex_load, a_mem_load, b_mem_load};

`ifdef FWD_HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_q <= '0;
        end else if (stall_raw && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule
